// File: rtl/dla_pkg.sv
// Shared widths, loader state encoding and kernel-geometry helpers for the DLA weight path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dla_pkg;

    localparam int DATA_WID = 16;   // INT16 weights
    localparam int ADDR_WID = 8;    // weight buffer address width
    localparam int MID_ADDR = 128;  // base of half 1; also capacity of one half
    localparam int NUM_SET  = 8;    // kernel-set buffers filled per load
    localparam int SET_WID  = 3;    // log2(NUM_SET)
    localparam int CHN_WID  = 7;    // kernels per set minus 1
    localparam int KSZ_WID  = 4;    // kernel side length
    localparam int SQ_WID   = 8;    // ksize^2 (wide enough for any 4-bit ksize)

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_WAIT_FREE = 3'd2,
        ST_LOAD      = 3'd3,
        ST_DONE      = 3'd4,
        ST_ERR       = 3'd5
    } ld_state_e;

    // Only odd kernel sides 1..11 are supported by img2col.
    function automatic logic ksize_legal(input logic [KSZ_WID-1:0] ksize);
        logic ok;
        case (ksize)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // One set buffer (chn_num+1 kernels of ksize^2 words) must fit in one half.
    function automatic logic fits_half(input logic [CHN_WID-1:0] chn,
                                       input logic [SQ_WID-1:0]  ksq);
        logic [14:0] words;
        words = ({8'd0, chn} + 15'd1) * {7'd0, ksq};
        return (words <= 15'(MID_ADDR));
    endfunction

endpackage

// File: rtl/wgt_load_addr_gen.sv
// Element/kernel/set counters producing the write address, set select and last-beat flag.
// Latency: combinational from counter state; counters advance on the accepted-beat strobe.
// Backpressure: none; counters simply hold while adv is low.
module wgt_load_addr_gen
    import dla_pkg::*;
(
    input  logic                clock,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                adv,
    input  logic [KSZ_WID-1:0]  ksize,
    input  logic [CHN_WID-1:0]  chn_last,
    input  logic                half,
    output logic [SQ_WID-1:0]   ksq,
    output logic [ADDR_WID-1:0] addr,
    output logic [NUM_SET-1:0]  set_oh,
    output logic                last_beat
);

    logic [SQ_WID-1:0]   elem_q;
    logic [CHN_WID-1:0]  kern_q;
    logic [SET_WID-1:0]  set_q;
    logic [ADDR_WID-2:0] kbase_q;    // kern_q * ksq, accumulated instead of multiplied
    logic                elem_last;
    logic                kern_last;
    logic                set_last;
    logic [ADDR_WID-2:0] offset;

    assign ksq       = {4'd0, ksize} * {4'd0, ksize};
    assign elem_last = (elem_q == ksq - 8'd1);
    assign kern_last = (kern_q == chn_last);
    assign set_last  = (set_q == SET_WID'(NUM_SET - 1));
    assign last_beat = elem_last && kern_last && set_last;

    // Capacity was checked before loading, so the in-half offset never exceeds 127.
    assign offset = kbase_q + elem_q[ADDR_WID-2:0];
    assign addr   = {half, offset};
    assign set_oh = NUM_SET'(1) << set_q;

    // Advance element, then kernel, then set on every accepted beat.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            elem_q  <= '0;
            kern_q  <= '0;
            set_q   <= '0;
            kbase_q <= '0;
        end else if (clr) begin
            elem_q  <= '0;
            kern_q  <= '0;
            set_q   <= '0;
            kbase_q <= '0;
        end else if (adv) begin
            if (elem_last) begin
                elem_q <= '0;
                if (kern_last) begin
                    kern_q  <= '0;
                    kbase_q <= '0;
                    set_q   <= set_q + SET_WID'(1);
                end else begin
                    kern_q  <= kern_q + CHN_WID'(1);
                    kbase_q <= kbase_q + ksq[ADDR_WID-2:0];
                end
            end else begin
                elem_q <= elem_q + SQ_WID'(1);
            end
        end
    end

endmodule

// File: rtl/wgt_buf_loader.sv
// Streams INT16 weights into one ping-pong half of the weight buffer, 8 kernel sets per load.
// Latency: beat accepted at cycle N is written at N+1; load_done one cycle after the last write.
// Backpressure: s_ready only in LOAD; a full target half stalls the load until released.
module wgt_buf_loader
    import dla_pkg::*;
(
    input  logic                clock,
    input  logic                rst_n,
    input  logic                load_start,
    input  logic [CHN_WID-1:0]  chn_num,
    input  logic [KSZ_WID-1:0]  kernel_size,
    input  logic                s_valid,
    input  logic [DATA_WID-1:0] s_data,
    output logic                s_ready,
    input  logic [1:0]          half_release,
    output logic                buf_wr_en,
    output logic [ADDR_WID-1:0] buf_wr_addr,
    output logic [DATA_WID-1:0] buf_wr_data,
    output logic [NUM_SET-1:0]  buf_set_sel,
    output logic [1:0]          half_full,
    output logic                load_busy,
    output logic                load_done,
    output logic                load_err
);

    ld_state_e           state_q;
    ld_state_e           state_d;
    logic [CHN_WID-1:0]  cfg_chn_q;
    logic [KSZ_WID-1:0]  cfg_ksz_q;
    logic                wr_half_q;
    logic [1:0]          half_full_q;
    logic [1:0]          half_full_d;
    logic                beat_acc;
    logic                cfg_ok;
    logic [SQ_WID-1:0]   ksq;
    logic [ADDR_WID-1:0] gen_addr;
    logic [NUM_SET-1:0]  gen_set_oh;
    logic                gen_last;

    assign s_ready   = (state_q == ST_LOAD);
    assign beat_acc  = s_valid && s_ready;
    assign load_busy = (state_q != ST_IDLE);
    assign half_full = half_full_q;
    assign cfg_ok    = ksize_legal(cfg_ksz_q) && fits_half(cfg_chn_q, ksq);

    wgt_load_addr_gen u_addr_gen (
        .clock     (clock),
        .rst_n     (rst_n),
        .clr       (state_q == ST_CHECK),
        .adv       (beat_acc),
        .ksize     (cfg_ksz_q),
        .chn_last  (cfg_chn_q),
        .half      (wr_half_q),
        .ksq       (ksq),
        .addr      (gen_addr),
        .set_oh    (gen_set_oh),
        .last_beat (gen_last)
    );

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: validate geometry, wait for a free half, stream, then finish or abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!cfg_ok) begin
                    state_d = ST_ERR;
                end else if (half_full_q[wr_half_q]) begin
                    state_d = ST_WAIT_FREE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_WAIT_FREE: begin
                if (!half_full_q[wr_half_q]) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat_acc && gen_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Latch load geometry once per accepted load_start; later input changes are ignored.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cfg_chn_q <= '0;
            cfg_ksz_q <= '0;
        end else if (state_q == ST_IDLE && load_start) begin
            cfg_chn_q <= chn_num;
            cfg_ksz_q <= kernel_size;
        end
    end

    // Releases clear their half; completing a load sets its half and overrides a same-cycle release.
    always_comb begin
        half_full_d = half_full_q & ~half_release;
        if (state_q == ST_DONE) begin
            half_full_d[wr_half_q] = 1'b1;
        end
    end

    // Half occupancy and ping-pong pointer.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            half_full_q <= 2'b00;
            wr_half_q   <= 1'b0;
        end else begin
            half_full_q <= half_full_d;
            if (state_q == ST_DONE) begin
                wr_half_q <= ~wr_half_q;
            end
        end
    end

    // Registered buffer write port: one cycle behind the accepted beat.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            buf_wr_en   <= 1'b0;
            buf_wr_addr <= '0;
            buf_wr_data <= '0;
            buf_set_sel <= '0;
        end else begin
            buf_wr_en   <= beat_acc;
            buf_set_sel <= beat_acc ? gen_set_oh : '0;
            if (beat_acc) begin
                buf_wr_addr <= gen_addr;
                buf_wr_data <= s_data;
            end
        end
    end

    // Completion/abort pulses, issued the cycle after DONE/ERR so done trails the last write.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            load_done <= (state_q == ST_DONE);
            load_err  <= (state_q == ST_ERR);
        end
    end

endmodule
